// File: rtl/gcd_pkg.sv
// Shared types for the streaming binary-GCD engine: FSM state encoding and
// the shift-count width helper.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Enough bits to count every common factor of two in a WIDTH-bit operand.
  function automatic int k_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/gcd_stream_if.sv
// Operand/result stream bundle for gcd_stream; the out_cycles field exists
// only when GCD_STREAM_CYCLES_EN is defined.
interface gcd_stream_if #(
  parameter int WIDTH = 16,
  parameter int CYC_W = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

`ifdef GCD_STREAM_CYCLES_EN
  logic [CYC_W-1:0]   out_cycles;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cycles
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cycles
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/gcd_step.sv
// One combinational Stein iteration. When a equals b the operands pass
// through unchanged and equal_o tells the FSM the reduction is complete.
module gcd_step #(
  parameter int WIDTH = 16,
  parameter int KW    = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [KW-1:0]    k_o,
  output logic             equal_o
);

  always_comb begin
    a_o     = a_i;
    b_o     = b_i;
    k_o     = k_i;
    equal_o = 1'b0;
    if (a_i == b_i) begin
      equal_o = 1'b1;
    end else if (!a_i[0] && !b_i[0]) begin
      a_o = a_i >> 1;
      b_o = b_i >> 1;
      k_o = k_i + KW'(1);
    end else if (!a_i[0]) begin
      a_o = a_i >> 1;
    end else if (!b_i[0]) begin
      b_o = b_i >> 1;
    end else if (a_i > b_i) begin
      // Both odd here, so the difference is even and the shift loses nothing.
      a_o = (a_i - b_i) >> 1;
    end else begin
      b_o = (b_i - a_i) >> 1;
    end
  end

endmodule

// File: rtl/gcd_stream.sv
// Iterative binary-GCD engine with valid/ready on both sides.
// Optional RUN-cycle counter on io.out_cycles when GCD_STREAM_CYCLES_EN is defined.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CYC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  gcd_stream_if.slave io
);

  localparam int KW = k_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] step_a, step_b;
  logic [KW-1:0]    step_k;
  logic             step_equal;

  assign in_a = io.in_data[WIDTH-1:0];
  assign in_b = io.in_data[2*WIDTH-1:WIDTH];

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .k_i     (k_q),
    .a_o     (step_a),
    .b_o     (step_b),
    .k_o     (step_k),
    .equal_o (step_equal)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d = in_a;
          b_d = in_b;
          k_d = '0;
          if (in_a == '0 || in_b == '0) begin
            out_data_d = in_a | in_b;
            state_d    = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (step_equal) begin
          out_data_d = a_q << k_q;
          state_d    = DONE;
        end else begin
          a_d = step_a;
          b_d = step_b;
          k_d = step_k;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;

`ifdef GCD_STREAM_CYCLES_EN
  logic [CYC_W-1:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (state_q == IDLE && io.in_valid) begin
      cycles_d = '0;
    end else if (state_q == RUN && cycles_q != '1) begin
      cycles_d = cycles_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign io.out_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_stream.sv
// Directed and table-driven checks of gcd_stream at WIDTH=16 and WIDTH=32,
// plus backpressure, no-bypass and mid-job reset sequences.
module tb_gcd_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_stream_if #(.WIDTH(16)) if16 ();
  gcd_stream_if #(.WIDTH(32)) if32 ();

  gcd_stream #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .io(if16));
  gcd_stream #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .io(if32));

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Presents one operand pair and waits (bounded) for the result.
  task automatic apply_stimulus16(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output int lat,
                                  output logic valid, output logic [7:0] cyc);
    if16.in_data  = {b, a};
    if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    lat = 0;
    while (!if16.out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    valid = if16.out_valid;
    res   = if16.out_data;
`ifdef GCD_STREAM_CYCLES_EN
    cyc = if16.out_cycles;
`else
    cyc = 8'd0;
`endif
  endtask

  task automatic apply_stimulus32(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic valid);
    int lat;
    if32.in_data  = {b, a};
    if32.in_valid = 1'b1;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    lat = 0;
    while (!if32.out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    valid = if32.out_valid;
    res   = if32.out_data;
  endtask

  initial begin
    logic [15:0] r16;
    logic [31:0] r32, ra, rb;
    int          lat;
    logic        vld;
    logic [7:0]  cyc;

    vecs[0]  = '{16'd48,    16'd18,    16'd6,     6};
    vecs[1]  = '{16'd0,     16'd7,     16'd7,     0};
    vecs[2]  = '{16'd0,     16'd0,     16'd0,     0};
    vecs[3]  = '{16'd7,     16'd0,     16'd7,     0};
    vecs[4]  = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  1};
    vecs[5]  = '{16'd35,    16'd21,    16'd7,     3};
    vecs[6]  = '{16'd100,   16'd75,    16'd25,    4};
    vecs[7]  = '{16'd1,     16'd1,     16'd1,     1};
    vecs[8]  = '{16'd12,    16'd18,    16'd6,     4};
    vecs[9]  = '{16'd1024,  16'd64,    16'd64,    11};
    vecs[10] = '{16'd17,    16'd13,    16'd1,     -1};
    vecs[11] = '{16'd65535, 16'd1,     16'd1,     -1};

    reset          = 1'b1;
    if16.in_valid  = 1'b0;
    if16.in_data   = '0;
    if16.out_ready = 1'b1;
    if32.in_valid  = 1'b0;
    if32.in_data   = '0;
    if32.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("reset_in_ready", 64'(if16.in_ready), 64'd1);
    check_output("reset_out_valid", 64'(if16.out_valid), 64'd0);
    check_output("reset_out_data", 64'(if16.out_data), 64'd0);
    check_output("reset_in_ready32", 64'(if32.in_ready), 64'd1);

    for (int i = 0; i < 12; i++) begin
      check_output($sformatf("v%0d_ready", i), 64'(if16.in_ready), 64'd1);
      apply_stimulus16(vecs[i].a, vecs[i].b, r16, lat, vld, cyc);
      check_output($sformatf("v%0d_valid", i), 64'(vld), 64'd1);
      check_output($sformatf("v%0d_data", i), 64'(r16), 64'(vecs[i].res));
      if (vecs[i].lat >= 0) begin
        check_output($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
`ifdef GCD_STREAM_CYCLES_EN
        check_output($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].lat));
`endif
      end
      @(posedge clk); #1;
      check_output($sformatf("v%0d_idle_after", i), 64'(if16.out_valid), 64'd0);
    end

    // Backpressure: result must hold and new operands must be ignored.
    if16.out_ready = 1'b0;
    apply_stimulus16(16'd48, 16'd18, r16, lat, vld, cyc);
    check_output("bp_first_data", 64'(r16), 64'd6);
    if16.in_valid = 1'b1;
    if16.in_data  = {16'd21, 16'd35};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_output($sformatf("bp%0d_valid", i), 64'(if16.out_valid), 64'd1);
      check_output($sformatf("bp%0d_data", i), 64'(if16.out_data), 64'd6);
      check_output($sformatf("bp%0d_in_ready", i), 64'(if16.in_ready), 64'd0);
    end
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    check_output("bp_handshake_valid", 64'(if16.out_valid), 64'd0);
    check_output("bp_no_bypass_ready", 64'(if16.in_ready), 64'd1);
    @(posedge clk); #1;
    check_output("bp_still_idle", 64'(if16.in_ready), 64'd1);

    // Reset in the middle of a long job.
    if16.in_data  = {16'd1, 16'd65535};
    if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("midrun_busy_ready", 64'(if16.in_ready), 64'd0);
    #2 reset = 1'b1;
    #1;
    check_output("midrun_reset_valid", 64'(if16.out_valid), 64'd0);
    check_output("midrun_reset_ready", 64'(if16.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    apply_stimulus16(16'd35, 16'd21, r16, lat, vld, cyc);
    check_output("after_reset_data", 64'(r16), 64'd7);
    check_output("after_reset_latency", 64'(lat), 64'd3);
    @(posedge clk); #1;

    // Wide instance: power-of-two corner and reference-checked pairs.
    apply_stimulus32(32'h8000_0000, 32'h4000_0000, r32, vld);
    check_output("w32_pow2_data", 64'(r32), 64'h4000_0000);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) begin
        ra = (ra >> 12) << (i % 7);
        rb = (rb >> 14) << (i % 5);
      end
      if (i == 5) ra = 32'd0;
      if (i == 9) rb = ra;
      apply_stimulus32(ra, rb, r32, vld);
      check_output($sformatf("w32_r%0d_valid", i), 64'(vld), 64'd1);
      check_output($sformatf("w32_r%0d_data", i), 64'(r32), 64'(gcd_ref(ra, rb)));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
